// File: rtl/pipe_wb_arb.sv
// Writeback arbiter: the EX pipe and the multi-cycle unit (mul/div) share a
// single register-file write port. EX has priority by default. An MDU
// result that is denied STARVE_MAX times in a row promotes the MDU to
// priority until that result is accepted. The result accepted in a cycle
// appears on the registered wb_* outputs one cycle later.
module pipe_wb_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_data_i,
    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        wb_valid_o,
    output logic        wb_wen_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_src_o
);

    typedef enum logic [0:0] {
        EX_PRI  = 1'b0,
        MDU_PRI = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  starve_cnt_r;
    logic        ex_grant_s;
    logic        mdu_grant_s;
    logic        mdu_denied_s;
    logic        starve_hit_s;

    // An MDU request that is pending but not granted this cycle.
    assign mdu_denied_s = mdu_valid_i && !mdu_grant_s;
    // True on the denial that brings the counter to its limit.
    assign starve_hit_s = mdu_denied_s &&
                          (({1'b0, starve_cnt_r} + 5'd1) >= {1'b0, STARVE_LIM});

    // Priority state register; reset returns to EX priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= EX_PRI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: promote the MDU when it has starved long enough, demote
    // it again as soon as its result is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EX_PRI: begin
                if (starve_hit_s) begin
                    state_next_s = MDU_PRI;
                end else begin
                    state_next_s = EX_PRI;
                end
            end
            MDU_PRI: begin
                if (mdu_valid_i && mdu_grant_s) begin
                    state_next_s = EX_PRI;
                end else begin
                    state_next_s = MDU_PRI;
                end
            end
            default: state_next_s = EX_PRI;
        endcase
    end

    // Grant decode: the favoured source wins, the other only when the
    // favoured one is idle. Nothing is granted while reset is held.
    always_comb begin
        ex_grant_s  = 1'b0;
        mdu_grant_s = 1'b0;
        if (rst_i) begin
            ex_grant_s  = 1'b0;
            mdu_grant_s = 1'b0;
        end else begin
            case (state_r)
                EX_PRI: begin
                    if (ex_valid_i) begin
                        ex_grant_s = 1'b1;
                    end else begin
                        mdu_grant_s = mdu_valid_i;
                    end
                end
                MDU_PRI: begin
                    if (mdu_valid_i) begin
                        mdu_grant_s = 1'b1;
                    end else begin
                        ex_grant_s = ex_valid_i;
                    end
                end
                default: begin
                    ex_grant_s  = 1'b0;
                    mdu_grant_s = 1'b0;
                end
            endcase
        end
    end

    assign ex_ready_o  = ex_grant_s;
    assign mdu_ready_o = mdu_grant_s;

    // Consecutive-denial counter for a waiting MDU result, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_r <= 4'd0;
        end else if (mdu_denied_s) begin
            if (starve_cnt_r < STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= 4'd0;
        end
    end

    // Writeback register: capture the accepted result; payload fields hold
    // their last value in idle cycles, valid and write enable drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_o <= 1'b0;
            wb_wen_o   <= 1'b0;
            wb_rd_o    <= 5'd0;
            wb_data_o  <= 32'd0;
            wb_src_o   <= 1'b0;
        end else if (ex_valid_i && ex_grant_s) begin
            wb_valid_o <= 1'b1;
            wb_wen_o   <= ex_wen_i && (ex_rd_i != 5'd0);
            wb_rd_o    <= ex_rd_i;
            wb_data_o  <= ex_data_i;
            wb_src_o   <= 1'b0;
        end else if (mdu_valid_i && mdu_grant_s) begin
            wb_valid_o <= 1'b1;
            wb_wen_o   <= (mdu_rd_i != 5'd0);
            wb_rd_o    <= mdu_rd_i;
            wb_data_o  <= mdu_data_i;
            wb_src_o   <= 1'b1;
        end else begin
            wb_valid_o <= 1'b0;
            wb_wen_o   <= 1'b0;
        end
    end

endmodule
